// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared constants and types for the registered half adder.
//   HA_WIDTH_DEFAULT : default lane count
//   HA_CNT_W_DEFAULT : default width of the optional carry-event counter
//   HA_MAX_WIDTH     : largest supported lane count
//   ha_result_t      : sum/carry pair, sized for the widest configuration;
//                      narrower users occupy the low WIDTH bits.
package half_adder_pkg;

  localparam int HA_WIDTH_DEFAULT = 1;
  localparam int HA_CNT_W_DEFAULT = 16;
  localparam int HA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic [HA_MAX_WIDTH-1:0] sum;
    logic [HA_MAX_WIDTH-1:0] carry;
  } ha_result_t;

endpackage

// File: rtl/half_adder_if.sv
// half_adder_if: operand/result bundle for half_adder.
//   in_valid, x, y   : operand side (driven by the master)
//   out_valid, s, c  : registered result side (driven by the slave)
//   carry_cnt        : carry-event count, only when HALF_ADDER_CARRY_CNT_EN
//                      is defined (CNT_W exists only in that build)
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEFAULT
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  parameter int CNT_W = HA_CNT_W_DEFAULT
`endif
);

  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt;

  modport master (output in_valid, x, y, input out_valid, s, c, carry_cnt);
  modport slave  (input in_valid, x, y, output out_valid, s, c, carry_cnt);
`else
  modport master (output in_valid, x, y, input out_valid, s, c);
  modport slave  (input in_valid, x, y, output out_valid, s, c);
`endif

endinterface

// File: rtl/half_adder_ha_cell.sv
// ha_cell: combinational 1-bit half adder.
//   a, b  : operand bits
//   sum   : a XOR b
//   carry : a AND b
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// half_adder: registered, lane-parallel half adder (WIDTH independent lanes).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : half_adder_if slave; x/y qualified by in_valid are captured as
//              s = x ^ y, c = x & y one cycle later with out_valid high.
//              With in_valid low, s/c hold and out_valid drops.
// Optional feature, macro HALF_ADDER_CARRY_CNT_EN: adds CNT_W and a
// saturating counter bus.carry_cnt of accepted inputs in which at least one
// lane produced a carry.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEFAULT
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  parameter int CNT_W = HA_CNT_W_DEFAULT
`endif
) (
  input  logic         clk,
  input  logic         rst,
  half_adder_if.slave  bus
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a     (bus.x[i]),
      .b     (bus.y[i]),
      .sum   (sum_w[i]),
      .carry (carry_w[i])
    );
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;
  logic             out_valid_d, out_valid_q;

  // The hold path is selected whenever in_valid is low, so unknown operands
  // on idle cycles never reach the registers.
  always_comb begin
    s_d         = s_q;
    c_d         = c_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      s_d = sum_w;
      c_d = carry_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.out_valid = out_valid_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

  // Saturating: stops at all-ones instead of wrapping.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (bus.in_valid && (|carry_w) && (carry_cnt_q != {CNT_W{1'b1}})) begin
      carry_cnt_d = carry_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign bus.carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: bench for half_adder with three instances sharing clk/rst:
//   dut_a WIDTH=1, dut_b WIDTH=4, dut_c WIDTH=2 (CNT_W=2 when the carry
//   counter is built). Directed steps followed by random traffic, all
//   checked against a lane-arithmetic reference model.
module tb_half_adder;
  import half_adder_pkg::*;

  localparam int CNT_MAX = 3;

  logic clk;
  logic rst;

  half_adder_if #(.WIDTH(1)) bus_a ();
  half_adder_if #(.WIDTH(4)) bus_b ();
`ifdef HALF_ADDER_CARRY_CNT_EN
  half_adder_if #(.WIDTH(2), .CNT_W(2)) bus_c ();
`else
  half_adder_if #(.WIDTH(2)) bus_c ();
`endif

  half_adder #(.WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  half_adder #(.WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
`ifdef HALF_ADDER_CARRY_CNT_EN
  half_adder #(.WIDTH(2), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
`else
  half_adder #(.WIDTH(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [63:0] es_a, ec_a, es_b, ec_b, es_c, ec_c;
  logic        ev_a, ev_b, ev_c;
  int          ecnt;

  logic sweep_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic sweep_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Each lane adds two one-bit numbers: sum is the low bit, carry the high.
  function automatic ha_result_t ha_ref(input logic [63:0] a, input logic [63:0] b);
    ha_result_t r;
    int t;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      t = (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
      r.sum[i]   = ((t % 2) == 1);
      r.carry[i] = ((t / 2) == 1);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    es_a = '0; ec_a = '0; ev_a = 1'b0;
    es_b = '0; ec_b = '0; ev_b = 1'b0;
    es_c = '0; ec_c = '0; ev_c = 1'b0;
    ecnt = 0;
  endtask

  task automatic check_all();
    chk("a_s", {63'b0, bus_a.s}, es_a);
    chk("a_c", {63'b0, bus_a.c}, ec_a);
    chk("a_vld", {63'b0, bus_a.out_valid}, {63'b0, ev_a});
    chk("b_s", {60'b0, bus_b.s}, es_b);
    chk("b_c", {60'b0, bus_b.c}, ec_b);
    chk("b_vld", {63'b0, bus_b.out_valid}, {63'b0, ev_b});
    chk("c_s", {62'b0, bus_c.s}, es_c);
    chk("c_c", {62'b0, bus_c.c}, ec_c);
    chk("c_vld", {63'b0, bus_c.out_valid}, {63'b0, ev_c});
`ifdef HALF_ADDER_CARRY_CNT_EN
    chk("c_cnt", {62'b0, bus_c.carry_cnt}, 64'(ecnt));
`endif
  endtask

  // Advance one clock edge, update the reference with what was presented at
  // that edge, then check every output 1 time unit after the edge.
  task automatic tick();
    logic        iva, ivb, ivc;
    logic [63:0] xa, ya, xb, yb, xc, yc;
    ha_result_t  r;
    iva = bus_a.in_valid; xa = {63'b0, bus_a.x}; ya = {63'b0, bus_a.y};
    ivb = bus_b.in_valid; xb = {60'b0, bus_b.x}; yb = {60'b0, bus_b.y};
    ivc = bus_c.in_valid; xc = {62'b0, bus_c.x}; yc = {62'b0, bus_c.y};
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      ev_a = iva;
      if (iva) begin r = ha_ref(xa, ya); es_a = r.sum; ec_a = r.carry; end
      ev_b = ivb;
      if (ivb) begin r = ha_ref(xb, yb); es_b = r.sum; ec_b = r.carry; end
      ev_c = ivc;
      if (ivc) begin
        r = ha_ref(xc, yc); es_c = r.sum; ec_c = r.carry;
        if (r.carry != 0 && ecnt < CNT_MAX) ecnt++;
      end
    end
    check_all();
  endtask

  task automatic idle_all();
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0; bus_c.in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] kk;
    // Reset state, checked before any clock edge
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.x = '0; bus_a.y = '0;
    bus_b.in_valid = 1'b0; bus_b.x = '0; bus_b.y = '0;
    bus_c.in_valid = 1'b0; bus_c.x = '0; bus_c.y = '0;
    model_reset();
    #3;
    check_all();
    // Valid input while reset is held must be ignored
    bus_a.in_valid = 1'b1; bus_a.x = 1'b1; bus_a.y = 1'b1;
    tick();
    tick();
    idle_all();
    rst = 1'b0;

    // Idle for 10 cycles, operands unknown on some of them
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        bus_a.x = 'x; bus_a.y = 'x; bus_b.x = 'x; bus_b.y = 'x; bus_c.x = 'x; bus_c.y = 'x;
      end else begin
        bus_a.x = 1'b1; bus_a.y = 1'b1; bus_b.x = 4'hf; bus_b.y = 4'hf; bus_c.x = 2'h3; bus_c.y = 2'h3;
      end
      tick();
      chk("idle_s", {63'b0, bus_a.s}, 64'd0);
    end

    // Exhaustive 1-bit sweep, back to back
    bus_a.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      bus_a.x = kk[1]; bus_a.y = kk[0];
      tick();
      chk("sweep_s", {63'b0, bus_a.s}, {63'b0, sweep_s[k]});
      chk("sweep_c", {63'b0, bus_a.c}, {63'b0, sweep_c[k]});
    end

    // Hold: capture 1+1, then toggle operands with in_valid low
    bus_a.x = 1'b1; bus_a.y = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_a.x = ~bus_a.x; bus_a.y = (i == 1) ? 1'b1 : 1'b0;
      tick();
      chk("hold_s", {63'b0, bus_a.s}, 64'd0);
      chk("hold_c", {63'b0, bus_a.c}, 64'd1);
    end

    // Multi-lane, no carry between lanes
    bus_b.in_valid = 1'b1; bus_b.x = 4'b1100; bus_b.y = 4'b1010;
    tick();
    chk("lane_s", {60'b0, bus_b.s}, 64'b0110);
    chk("lane_c", {60'b0, bus_b.c}, 64'b1000);
    bus_b.in_valid = 1'b0;

    // Asynchronous reset between edges discards an in-flight result
    bus_a.in_valid = 1'b1; bus_a.x = 1'b1; bus_a.y = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.x = 4'b0111; bus_b.y = 4'b0101;
    tick();
    bus_a.x = 1'b1; bus_a.y = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.x = 1'b1; bus_a.y = 1'b0;
    tick();
    chk("post_rst_s", {63'b0, bus_a.s}, 64'd1);
    bus_a.in_valid = 1'b0;

    // Carry counter saturation, then a carry-free input
    bus_c.in_valid = 1'b1; bus_c.x = 2'b01; bus_c.y = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
`ifdef HALF_ADDER_CARRY_CNT_EN
      chk("cnt_sat", {62'b0, bus_c.carry_cnt}, 64'((i < 3) ? i + 1 : 3));
`endif
    end
    bus_c.x = 2'b01; bus_c.y = 2'b10;
    tick();
`ifdef HALF_ADDER_CARRY_CNT_EN
    chk("cnt_nocarry", {62'b0, bus_c.carry_cnt}, 64'd3);
`endif
    chk("c_nocarry_s", {62'b0, bus_c.s}, 64'b11);
    bus_c.in_valid = 1'b0;

    // Random traffic with occasional synchronous-timed reset pulses
    for (int i = 0; i < 300; i++) begin
      bus_a.in_valid = 1'($urandom); bus_a.x = 1'($urandom); bus_a.y = 1'($urandom);
      bus_b.in_valid = 1'($urandom); bus_b.x = 4'($urandom); bus_b.y = 4'($urandom);
      bus_c.in_valid = 1'($urandom); bus_c.x = 2'($urandom); bus_c.y = 2'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
